// File: rtl/ram_block_mover.sv
// Initiator for the single-port word RAM: loads the image, copies count words src->dst
// in ascending order, optionally dumps the image (RAM_MOVER_DUMP_EN), then pulses done.
module ram_block_mover #(
  parameter int unsigned MEMSIZE     = 16,
  parameter int unsigned ADDRESSSIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] srcBase,
  input  logic [ADDRESSSIZE-1:0] dstBase,
  input  logic [ADDRESSSIZE:0]   count,
  input  logic [MEMSIZE-1:0]     ramReadData,
  output logic [ADDRESSSIZE-1:0] ramAddress,
  output logic [MEMSIZE-1:0]     ramWriteData,
  output logic                   ramEnWrite,
  output logic                   ramEnRead,
  output logic                   ramReadFile,
  output logic                   ramWriteFile,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {StIdle, StLoad, StRead, StWrite, StDump, StDone} state_e;

  localparam logic [ADDRESSSIZE-1:0] AddrOne = 1;
  localparam logic [ADDRESSSIZE:0]   CntOne  = 1;

  state_e                 state_q;
  logic [ADDRESSSIZE-1:0] src_q, dst_q, idx_q, addr_q;
  logic [ADDRESSSIZE:0]   cnt_q;
  logic [MEMSIZE-1:0]     hold_q;
  logic                   en_rd_q, en_wr_q, rd_file_q, busy_q, done_q;
  logic                   last;

`ifdef RAM_MOVER_DUMP_EN
  localparam state_e StFinish = StDump;
  logic wr_file_q;
  assign ramWriteFile = wr_file_q;
`else
  localparam state_e StFinish = StDone;
  assign ramWriteFile = 1'b0;
`endif

  assign last = ({1'b0, idx_q} == (cnt_q - CntOne));

  // Outputs are registered alongside the state, so each is set on entry to its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      addr_q    <= '0;
      en_rd_q   <= 1'b0;
      en_wr_q   <= 1'b0;
      rd_file_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef RAM_MOVER_DUMP_EN
      wr_file_q <= 1'b0;
`endif
    end else begin
      addr_q    <= '0;
      en_rd_q   <= 1'b0;
      en_wr_q   <= 1'b0;
      rd_file_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
`ifdef RAM_MOVER_DUMP_EN
      wr_file_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          busy_q <= start;
          if (start) begin
            src_q     <= srcBase;
            dst_q     <= dstBase;
            cnt_q     <= count;
            idx_q     <= '0;
            rd_file_q <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (cnt_q != '0) begin
            en_rd_q <= 1'b1;
            addr_q  <= src_q;
            state_q <= StRead;
          end else begin
            state_q <= StFinish;
            done_q  <= (StFinish == StDone);
`ifdef RAM_MOVER_DUMP_EN
            wr_file_q <= 1'b1;
`endif
          end
        end
        StRead: begin
          hold_q  <= ramReadData;
          en_wr_q <= 1'b1;
          addr_q  <= dst_q + idx_q;
          state_q <= StWrite;
        end
        StWrite: begin
          if (last) begin
            state_q <= StFinish;
            done_q  <= (StFinish == StDone);
`ifdef RAM_MOVER_DUMP_EN
            wr_file_q <= 1'b1;
`endif
          end else begin
            idx_q   <= idx_q + AddrOne;
            en_rd_q <= 1'b1;
            addr_q  <= src_q + idx_q + AddrOne;
            state_q <= StRead;
          end
        end
        StDump: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ramAddress   = addr_q;
  assign ramWriteData = hold_q & {MEMSIZE{en_wr_q}};
  assign ramEnRead    = en_rd_q;
  assign ramEnWrite   = en_wr_q;
  assign ramReadFile  = rd_file_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover with a behavioural RAM and a read/write scoreboard.
module tb_ram_block_mover;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  srcBase = '0, dstBase = '0;
  logic [4:0]  count = '0;
  logic [15:0] ramReadData;
  logic [3:0]  ramAddress;
  logic [15:0] ramWriteData;
  logic        ramEnWrite, ramEnRead, ramReadFile, ramWriteFile, busy, done;

  logic [15:0] mem [16];
  logic [15:0] img [16];
  logic [15:0] dumped [16];
  logic [3:0]  rd_q [$];
  logic [19:0] wr_q [$];
  int          tests = 0;
  int          fails = 0;

  ram_block_mover #(.MEMSIZE(16), .ADDRESSSIZE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .srcBase(srcBase), .dstBase(dstBase), .count(count),
    .ramReadData(ramReadData), .ramAddress(ramAddress), .ramWriteData(ramWriteData),
    .ramEnWrite(ramEnWrite), .ramEnRead(ramEnRead), .ramReadFile(ramReadFile),
    .ramWriteFile(ramWriteFile), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign ramReadData = mem[ramAddress];
  always @(posedge clk) begin
    if (ramReadFile) mem <= img;
    else if (ramEnWrite) mem[ramAddress] <= ramWriteData;
    if (ramWriteFile) dumped <= mem;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: every RAM access is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      chk("exclusive", 32'({ramEnRead & ramEnWrite,
                            (ramReadFile | ramWriteFile) & (ramEnRead | ramEnWrite)}), 0);
      if (!ramEnWrite) chk("wdata idle", 32'(ramWriteData), 0);
      if (!ramEnRead && !ramEnWrite) chk("addr idle", 32'(ramAddress), 0);
      if (ramEnRead) begin
        if (rd_q.size() == 0) chk("read pending", 32'(rd_q.size()), 1);
        else chk("read addr", 32'(ramAddress), 32'(rd_q.pop_front()));
      end
      if (ramEnWrite) begin
        if (wr_q.size() == 0) chk("write pending", 32'(wr_q.size()), 1);
        else chk("write addr/data", 32'({ramAddress, ramWriteData}), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic run_copy(input int src, input int dst, input int cnt, input int poke_at);
    logic [15:0] e [16];
    int s, d, done_at, rdf, wrf, wrf_at, en_cyc, exp_done;
    e = img;
    for (int k = 0; k < cnt; k++) begin
      s = (src + k) % 16;
      d = (dst + k) % 16;
      e[d] = e[s];
      rd_q.push_back(4'(s));
      wr_q.push_back({4'(d), e[d]});
    end
`ifdef RAM_MOVER_DUMP_EN
    exp_done = 2 * cnt + 3;
`else
    exp_done = 2 * cnt + 2;
`endif
    @(posedge clk); #1;
    srcBase = 4'(src); dstBase = 4'(dst); count = 5'(cnt); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; srcBase = ~srcBase; dstBase = 4'($urandom); count = 5'($urandom);
    done_at = 0; rdf = 0; wrf = 0; wrf_at = 0; en_cyc = 0;
    for (int k = 1; k <= 2 * cnt + 40 && done_at == 0; k++) begin
      @(negedge clk);
      start = (k == poke_at);
      if (k == poke_at) begin srcBase = 4'd9; dstBase = 4'd3; count = 5'd2; end
      chk("busy", 32'(busy), 1);
      if (ramReadFile) begin rdf++; chk("load cycle", k, 1); end
      if (ramWriteFile) begin wrf++; wrf_at = k; end
      if (ramEnRead || ramEnWrite) en_cyc++;
      if (done) done_at = k;
    end
    start = 1'b0;
    chk("done cycle", done_at, exp_done);
    chk("load pulses", rdf, 1);
    chk("enable cycles", en_cyc, 2 * cnt);
`ifdef RAM_MOVER_DUMP_EN
    chk("dump pulses", wrf, 1);
    chk("dump before done", wrf_at, done_at - 1);
`else
    chk("dump pulses", wrf, 0);
`endif
    @(negedge clk);
    chk("idle after done", 32'({busy, done}), 0);
    chk("queues drained", rd_q.size() + wr_q.size(), 0);
    for (int k = 0; k < 16; k++) chk($sformatf("mem[%0d]", k), 32'(mem[k]), 32'(e[k]));
`ifdef RAM_MOVER_DUMP_EN
    for (int k = 0; k < 16; k++) chk($sformatf("dump[%0d]", k), 32'(dumped[k]), 32'(e[k]));
`endif
  endtask

  initial begin
    logic [15:0] e [16];
    for (int k = 0; k < 16; k++) begin mem[k] = '0; dumped[k] = '0; img[k] = 16'(k); end
    #12;
    chk("reset outputs", 32'({ramAddress, ramWriteData, ramEnWrite, ramEnRead, ramReadFile,
                              ramWriteFile, busy, done}), 0);
    @(posedge clk); #1 rst = 1'b0;

    run_copy(2, 8, 4, 0);          // basic copy
    run_copy(3, 5, 0, 0);          // count = 0
    run_copy(14, 1, 4, 0);         // wrap-around with overlap propagation
    run_copy(0, 0, 16, 7);         // full copy, start pulse while busy ignored

    // Reset during the second WRITE of a count=5 copy.
    for (int k = 0; k < 16; k++) img[k] = 16'hA000 | 16'(k);
    e = img;
    e[8] = img[0];
    for (int k = 0; k < 5; k++) begin
      rd_q.push_back(4'(k));
      wr_q.push_back({4'(8 + k), img[k]});
    end
    @(posedge clk); #1;
    srcBase = 4'd0; dstBase = 4'd8; count = 5'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    chk("second write seen", 32'(ramEnWrite), 1);
    #2 rst = 1'b1;
    #1 chk("outputs in reset", 32'({ramAddress, ramWriteData, ramEnWrite, ramEnRead,
                                     ramReadFile, ramWriteFile, busy, done}), 0);
    rd_q.delete();
    wr_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) chk($sformatf("rst mem[%0d]", k), 32'(mem[k]), 32'(e[k]));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no done after reset", 32'({busy, done}), 0);
    end

    for (int k = 0; k < 16; k++) img[k] = 16'h5500 + 16'(k);
    run_copy(5, 6, 3, 0);          // restart after reset, overlapping forward copy

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
